// File: rtl/alu_seq_pkg.sv
// Shared types for alu_seq: operation encoding, controller states and legal WIDTH bounds.
package alu_seq_pkg;

  localparam int WIDTH_MIN = 4;
  localparam int WIDTH_MAX = 32;

  typedef enum logic [2:0] {
    FUNC_ADD = 3'b000,
    FUNC_SUB = 3'b001,
    FUNC_AND = 3'b010,
    FUNC_OR  = 3'b011,
    FUNC_XOR = 3'b100,
    FUNC_SHL = 3'b101,
    FUNC_SHR = 3'b110,
    FUNC_MUL = 3'b111
  } func_e;

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } state_e;

endpackage

// File: rtl/alu_mul_seq.sv
// Shift-add multiplier, one multiplier bit per cycle; done is high for the
// cycle after the last of WIDTH iterations, with the full product on product_o.
module alu_mul_seq #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic               done_o,
  output logic [2*WIDTH-1:0] product_o
);

  localparam int CW = $clog2(WIDTH + 1);

  logic               busy_q, busy_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;

  // Iteration datapath: load on start, then add-and-shift until the count runs out.
  always_comb begin
    busy_d   = busy_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    if (start_i) begin
      busy_d   = 1'b1;
      cnt_d    = CW'(WIDTH);
      mcand_d  = {{WIDTH{1'b0}}, a_i};
      mplier_d = b_i;
      acc_d    = {(2*WIDTH){1'b0}};
    end else if (busy_q && (cnt_q != '0)) begin
      if (mplier_q[0]) begin
        acc_d = acc_q + mcand_q;
      end else begin
        acc_d = acc_q;
      end
      mcand_d  = {mcand_q[2*WIDTH-2:0], 1'b0};
      mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
      cnt_d    = cnt_q - CW'(1);
    end else if (busy_q) begin
      busy_d = 1'b0;
    end else begin
      busy_d = 1'b0;
    end
  end

  // Multiplier state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q   <= 1'b0;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
    end else begin
      busy_q   <= busy_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
    end
  end

  assign done_o    = busy_q && (cnt_q == '0);
  assign product_o = acc_q;

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU with valid/ready handshake and registered result/flags.
// Define ALU_SEQ_MUL_EN to build in the multi-cycle shift-add MUL (func 111).
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] inputA,
  input  logic [WIDTH-1:0] inputB,
  input  logic             carryIn,
  input  logic [2:0]       func,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carryOut,
  output logic             zero,
  output logic             negetive
);

  func_e            func_s;
  logic             accept;
  logic             alu_done;
  logic [WIDTH-1:0] alu_res;
  logic             alu_cout;
  logic             load_en;
  logic [WIDTH-1:0] load_res;
  logic             load_cout;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_q, carry_d;
  logic             zero_q, zero_d;
  logic             neg_q, neg_d;

  assign func_s = func_e'(func);
  assign accept = in_valid && in_ready;

`ifdef ALU_SEQ_MUL_EN
  state_e             state_q, state_d;
  logic               mul_start;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_product;

  assign mul_start = accept && (func_s == FUNC_MUL);
  assign alu_done  = accept && (func_s != FUNC_MUL);
  assign in_ready  = (state_q == IDLE) && (!out_valid_q || out_ready);

  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_i   (mul_start),
    .a_i       (inputA),
    .b_i       (inputB),
    .done_o    (mul_done),
    .product_o (mul_product)
  );

  // Controller: sit in MUL until the multiplier reports done.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (mul_start) begin
          state_d = MUL;
        end else begin
          state_d = IDLE;
        end
      end
      MUL: begin
        if (mul_done) begin
          state_d = IDLE;
        end else begin
          state_d = MUL;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Controller state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Completion source: a finishing multiply or a single-cycle op.
  always_comb begin
    load_en   = alu_done;
    load_res  = alu_res;
    load_cout = alu_cout;
    if ((state_q == MUL) && mul_done) begin
      load_en   = 1'b1;
      load_res  = mul_product[WIDTH-1:0];
      load_cout = |mul_product[2*WIDTH-1:WIDTH];
    end else begin
      load_en   = alu_done;
      load_res  = alu_res;
      load_cout = alu_cout;
    end
  end
`else
  assign alu_done  = accept;
  assign in_ready  = !out_valid_q || out_ready;
  assign load_en   = alu_done;
  assign load_res  = alu_res;
  assign load_cout = alu_cout;
`endif

  // Single-cycle operations; func 111 yields zero here and is overridden by MUL when built in.
  always_comb begin
    alu_res  = {WIDTH{1'b0}};
    alu_cout = 1'b0;
    case (func_s)
      FUNC_ADD: {alu_cout, alu_res} = {1'b0, inputA} + {1'b0, inputB} + {{WIDTH{1'b0}}, carryIn};
      FUNC_SUB: {alu_cout, alu_res} = {1'b0, inputA} + {1'b0, ~inputB} + {{WIDTH{1'b0}}, carryIn};
      FUNC_AND: alu_res = inputA & inputB;
      FUNC_OR:  alu_res = inputA | inputB;
      FUNC_XOR: alu_res = inputA ^ inputB;
      FUNC_SHL: begin
        alu_res  = {inputA[WIDTH-2:0], 1'b0};
        alu_cout = inputA[WIDTH-1];
      end
      FUNC_SHR: begin
        alu_res  = {1'b0, inputA[WIDTH-1:1]};
        alu_cout = inputA[0];
      end
      default: begin
        alu_res  = {WIDTH{1'b0}};
        alu_cout = 1'b0;
      end
    endcase
  end

  // Output stage: a completion loads even while draining, so accept-and-drain has no bubble.
  always_comb begin
    out_valid_d = out_valid_q;
    result_d    = result_q;
    carry_d     = carry_q;
    zero_d      = zero_q;
    neg_d       = neg_q;
    if (load_en) begin
      out_valid_d = 1'b1;
      result_d    = load_res;
      carry_d     = load_cout;
      zero_d      = (load_res == {WIDTH{1'b0}});
      neg_d       = load_res[WIDTH-1];
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      carry_q     <= 1'b0;
      zero_q      <= 1'b0;
      neg_q       <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      carry_q     <= carry_d;
      zero_q      <= zero_d;
      neg_q       <= neg_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign carryOut  = carry_q;
  assign zero      = zero_q;
  assign negetive  = neg_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq at WIDTH=8; MUL vectors run when ALU_SEQ_MUL_EN is defined.
module tb_alu_seq;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] inputA;
  logic [7:0] inputB;
  logic       carryIn;
  logic [2:0] func;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] result;
  logic       carryOut;
  logic       zero;
  logic       negetive;

  int n_checks = 0;
  int n_errors = 0;

  alu_seq #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .inputA    (inputA),
    .inputB    (inputB),
    .carryIn   (carryIn),
    .func      (func),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .carryOut  (carryOut),
    .zero      (zero),
    .negetive  (negetive)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present a request and hold it until accepted (bounded); returns just after the accepting edge.
  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic cin, input logic [2:0] f);
    int waited;
    waited   = 0;
    in_valid = 1'b1;
    inputA   = a;
    inputB   = b;
    carryIn  = cin;
    func     = f;
    @(negedge clk);
    while (!in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    check_eq("accept_wait", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic expect_res(input string tag, input logic [7:0] r, input logic c, input logic z, input logic n);
    @(negedge clk);
    check_eq({tag, "_valid"}, 32'(out_valid), 32'd1);
    check_eq({tag, "_result"}, 32'(result), 32'(r));
    check_eq({tag, "_carry"}, 32'(carryOut), 32'(c));
    check_eq({tag, "_zero"}, 32'(zero), 32'(z));
    check_eq({tag, "_neg"}, 32'(negetive), 32'(n));
  endtask

  initial begin
    int lat;
    int stale;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    inputA    = 8'h00;
    inputB    = 8'h00;
    carryIn   = 1'b0;
    func      = 3'b000;
    out_ready = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_valid", 32'(out_valid), 32'd0);
    check_eq("rst_result", 32'(result), 32'd0);
    check_eq("rst_carry", 32'(carryOut), 32'd0);
    check_eq("rst_zero", 32'(zero), 32'd0);
    check_eq("rst_neg", 32'(negetive), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    send(8'hF9, 8'h84, 1'b1, 3'b000); expect_res("add_carry", 8'h7E, 1'b1, 1'b0, 1'b0);
    send(8'h10, 8'h10, 1'b1, 3'b001); expect_res("sub_eq",    8'h00, 1'b1, 1'b1, 1'b0);
    send(8'h05, 8'h07, 1'b1, 3'b001); expect_res("sub_neg",   8'hFE, 1'b0, 1'b0, 1'b1);
    send(8'h7F, 8'h01, 1'b0, 3'b000); expect_res("add_ovf",   8'h80, 1'b0, 1'b0, 1'b1);
    send(8'hF0, 8'h3C, 1'b1, 3'b010); expect_res("and",       8'h30, 1'b0, 1'b0, 1'b0);
    send(8'h81, 8'h02, 1'b1, 3'b011); expect_res("or",        8'h83, 1'b0, 1'b0, 1'b1);
    send(8'hAA, 8'hAA, 1'b0, 3'b100); expect_res("xor",       8'h00, 1'b0, 1'b1, 1'b0);
    send(8'h81, 8'h00, 1'b0, 3'b101); expect_res("shl",       8'h02, 1'b1, 1'b0, 1'b0);
    send(8'h81, 8'h00, 1'b0, 3'b110); expect_res("shr",       8'h40, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    check_eq("drain_clear", 32'(out_valid), 32'd0);

    // Backpressure: first result must hold while the second request waits.
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    send(8'h01, 8'h02, 1'b0, 3'b000);
    in_valid = 1'b1;
    inputA   = 8'h10;
    inputB   = 8'h20;
    carryIn  = 1'b0;
    func     = 3'b000;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq("bp_valid", 32'(out_valid), 32'd1);
      check_eq("bp_hold", 32'(result), 32'h03);
      check_eq("bp_ready", 32'(in_ready), 32'd0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(negedge clk);
    check_eq("bp_release_ready", 32'(in_ready), 32'd1);
    check_eq("bp_release_hold", 32'(result), 32'h03);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    check_eq("bp_second_valid", 32'(out_valid), 32'd1);
    check_eq("bp_second_result", 32'(result), 32'h30);
    @(negedge clk);
    check_eq("bp_second_drained", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;

`ifdef ALU_SEQ_MUL_EN
    send(8'h0F, 8'h11, 1'b0, 3'b111);
    @(negedge clk);
    check_eq("mul_busy_ready", 32'(in_ready), 32'd0);
    check_eq("mul_busy_valid", 32'(out_valid), 32'd0);
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end while (!out_valid && lat < 40);
    check_eq("mul_latency", 32'(lat), 32'd9);
    check_eq("mul_ff_result", 32'(result), 32'hFF);
    check_eq("mul_ff_carry", 32'(carryOut), 32'd0);
    check_eq("mul_ff_zero", 32'(zero), 32'd0);
    check_eq("mul_ff_neg", 32'(negetive), 32'd1);
    @(posedge clk);
    #1;

    send(8'h80, 8'h02, 1'b0, 3'b111);
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end while (!out_valid && lat < 40);
    check_eq("mul_ovf_latency", 32'(lat), 32'd9);
    check_eq("mul_ovf_result", 32'(result), 32'h00);
    check_eq("mul_ovf_carry", 32'(carryOut), 32'd1);
    check_eq("mul_ovf_zero", 32'(zero), 32'd1);
    check_eq("mul_ovf_neg", 32'(negetive), 32'd0);
    @(posedge clk);
    #1;
`else
    send(8'h0F, 8'h11, 1'b0, 3'b111);
    expect_res("nomul", 8'h00, 1'b0, 1'b1, 1'b0);
    @(posedge clk);
    #1;
`endif

    // Reset mid-operation: leave a nonzero stale result, then abort.
    send(8'hF9, 8'h84, 1'b1, 3'b000);
    expect_res("pre_rst", 8'h7E, 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #1;
`ifdef ALU_SEQ_MUL_EN
    send(8'h0F, 8'h11, 1'b0, 3'b111);
`endif
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("arst_valid", 32'(out_valid), 32'd0);
    check_eq("arst_result", 32'(result), 32'd0);
    check_eq("arst_carry", 32'(carryOut), 32'd0);
    check_eq("arst_zero", 32'(zero), 32'd0);
    check_eq("arst_neg", 32'(negetive), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_eq("post_rst_ready", 32'(in_ready), 32'd1);
    stale = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    check_eq("no_stale_result", 32'(stale), 32'd0);
    @(posedge clk);
    #1;
    send(8'h33, 8'h44, 1'b0, 3'b000);
    expect_res("post_rst_add", 8'h77, 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
